id_ex_operand_stage: RTL and testbench

//  ID/EX pipeline register plus execute-stage operand selection; directly upstream of the ALU.
//  - Captures decode-stage operands and control each cycle.
//  - Applies hazard-unit stall/flush.
//  - Resolves forwarding and immediate selection, driving SrcAE/SrcBE/ALUControlE into the ALU.
//  - Also drives WriteDataE/WriteRegE/control toward EX/MEM.

---
 rtl/mips_pkg.sv | 23 ++
 rtl/id_ex_operand_stage_if.sv | 59 +++++
 rtl/id_ex_operand_stage_fwd_mux3.sv | 24 ++
 rtl/id_ex_operand_stage.sv | 118 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline constants: widths, ALU ops, forward selects
package mips_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int CTRL_W_DEF = 3;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b100,
    ALU_MUL = 3'b101,
    ALU_SLT = 3'b110
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// rtl/id_ex_operand_stage_if.sv - decode/hazard/forward inputs and execute outputs of the ID/EX stage
interface id_ex_operand_stage_if
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = CTRL_W_DEF
);
  // decode-stage operands and control
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic [DATA_W-1:0] SignImmD;
  logic [REG_AW-1:0] RsD;
  logic [REG_AW-1:0] RtD;
  logic [REG_AW-1:0] RdD;
  logic              RegWriteD;
  logic              MemtoRegD;
  logic              MemWriteD;
  logic              ALUSrcD;
  logic              RegDstD;
  logic [CTRL_W-1:0] ALUControlD;
  // hazard unit
  logic              StallE;
  logic              FlushE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  // later-stage results for forwarding
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] ResultW;
  // execute-stage outputs
  logic [DATA_W-1:0] SrcAE;
  logic [DATA_W-1:0] SrcBE;
  logic [CTRL_W-1:0] ALUControlE;
  logic [DATA_W-1:0] WriteDataE;
  logic [REG_AW-1:0] WriteRegE;
  logic [REG_AW-1:0] RsE;
  logic [REG_AW-1:0] RtE;
  logic              RegWriteE;
  logic              MemtoRegE;
  logic              MemWriteE;
  logic              ValidE;

  modport master (
    output RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    output RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
    output StallE, FlushE, ForwardAE, ForwardBE, ALUOutM, ResultW,
    input  SrcAE, SrcBE, ALUControlE, WriteDataE, WriteRegE, RsE, RtE,
    input  RegWriteE, MemtoRegE, MemWriteE, ValidE
  );

  modport slave (
    input  RD1D, RD2D, SignImmD, RsD, RtD, RdD,
    input  RegWriteD, MemtoRegD, MemWriteD, ALUSrcD, RegDstD, ALUControlD,
    input  StallE, FlushE, ForwardAE, ForwardBE, ALUOutM, ResultW,
    output SrcAE, SrcBE, ALUControlE, WriteDataE, WriteRegE, RsE, RtE,
    output RegWriteE, MemtoRegE, MemWriteE, ValidE
  );

endinterface

// File: rtl/id_ex_operand_stage_fwd_mux3.sv
// rtl/id_ex_operand_stage_fwd_mux3.sv - 3:1 forwarding mux, select 11 falls back to the register value
module fwd_mux3
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] regIn,
  input  logic [DATA_W-1:0] wbIn,
  input  logic [DATA_W-1:0] memIn,
  input  logic [1:0]        sel,
  output logic [DATA_W-1:0] muxOut
);

  // pick forwarded source; the unused code 11 behaves like 00 so nothing goes X
  always_comb begin
    muxOut = regIn;
    case (sel)
      FWD_WB:  muxOut = wbIn;
      FWD_MEM: muxOut = memIn;
      default: muxOut = regIn;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX register with forwarding and ALU operand select; IDEX_PERF_CNT_EN adds bubble/stall counters
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int CNT_W  = 16
) (
  input logic clk,
  input logic rst_n,
  id_ex_operand_stage_if.slave bus
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] BubbleCnt,
  output logic [CNT_W-1:0] StallCnt
`endif
);

  logic [DATA_W-1:0] rd1E;
  logic [DATA_W-1:0] rd2E;
  logic [DATA_W-1:0] signImmE;
  logic [REG_AW-1:0] rsE;
  logic [REG_AW-1:0] rtE;
  logic [REG_AW-1:0] rdE;
  logic              regWriteE;
  logic              memtoRegE;
  logic              memWriteE;
  logic              aluSrcE;
  logic              regDstE;
  logic [CTRL_W-1:0] aluControlE;
  logic              validE;

  logic [DATA_W-1:0] srcA;
  logic [DATA_W-1:0] writeData;

  // pipeline register: reset, then flush (bubble), then stall (hold), else capture
  always_ff @(posedge clk) begin
    if (!rst_n || bus.FlushE) begin
      rd1E        <= '0;
      rd2E        <= '0;
      signImmE    <= '0;
      rsE         <= '0;
      rtE         <= '0;
      rdE         <= '0;
      regWriteE   <= 1'b0;
      memtoRegE   <= 1'b0;
      memWriteE   <= 1'b0;
      aluSrcE     <= 1'b0;
      regDstE     <= 1'b0;
      aluControlE <= '0;
      validE      <= 1'b0;
    end else if (!bus.StallE) begin
      rd1E        <= bus.RD1D;
      rd2E        <= bus.RD2D;
      signImmE    <= bus.SignImmD;
      rsE         <= bus.RsD;
      rtE         <= bus.RtD;
      rdE         <= bus.RdD;
      regWriteE   <= bus.RegWriteD;
      memtoRegE   <= bus.MemtoRegD;
      memWriteE   <= bus.MemWriteD;
      aluSrcE     <= bus.ALUSrcD;
      regDstE     <= bus.RegDstD;
      aluControlE <= bus.ALUControlD;
      validE      <= 1'b1;
    end
  end

  fwd_mux3 #(.DATA_W(DATA_W)) uFwdA (
    .regIn  (rd1E),
    .wbIn   (bus.ResultW),
    .memIn  (bus.ALUOutM),
    .sel    (bus.ForwardAE),
    .muxOut (srcA)
  );

  fwd_mux3 #(.DATA_W(DATA_W)) uFwdB (
    .regIn  (rd2E),
    .wbIn   (bus.ResultW),
    .memIn  (bus.ALUOutM),
    .sel    (bus.ForwardBE),
    .muxOut (writeData)
  );

  // operand B takes the immediate or the forwarded store data; destination picks rd or rt
  always_comb begin
    bus.SrcAE       = srcA;
    bus.WriteDataE  = writeData;
    bus.SrcBE       = aluSrcE ? signImmE : writeData;
    bus.WriteRegE   = regDstE ? rdE : rtE;
    bus.ALUControlE = aluControlE;
    bus.RsE         = rsE;
    bus.RtE         = rtE;
    bus.RegWriteE   = regWriteE;
    bus.MemtoRegE   = memtoRegE;
    bus.MemWriteE   = memWriteE;
    bus.ValidE      = validE;
  end

`ifdef IDEX_PERF_CNT_EN
  // saturating counters of flush cycles and of stall cycles that were not overridden by a flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BubbleCnt <= '0;
      StallCnt  <= '0;
    end else begin
      if (bus.FlushE && (BubbleCnt != '1)) begin
        BubbleCnt <= BubbleCnt + CNT_W'(1);
      end
      if (bus.StallE && !bus.FlushE && (StallCnt != '1)) begin
        StallCnt <= StallCnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - table-driven scoreboard bench for id_ex_operand_stage
module tb_id_ex_operand_stage;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        regWrite, memtoReg, memWrite, aluSrc, regDst;
    logic [2:0]  aluCtrl;
    logic        stall, flush;
    logic [1:0]  fwdA, fwdB;
    logic [31:0] aluOutM, resultW;
  } vec_in_t;

  typedef struct {
    logic [31:0] srcA, srcB, writeData;
    logic [2:0]  aluCtrl;
    logic [4:0]  writeReg, rs, rt;
    logic        regWrite, memtoReg, memWrite, valid;
  } vec_out_t;

  typedef struct {
    string    name;
    vec_in_t  in;
    vec_out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nTests = 0;
  int   nFail = 0;

  vec_out_t expQ[$];
  string    nameQ[$];
  vec_t     vecs[9];

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) bus ();

`ifdef IDEX_PERF_CNT_EN
  logic [15:0] bubbleCnt, stallCnt;
  logic [1:0]  bubbleCnt2, stallCnt2;
  id_ex_operand_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) bus2 ();
  assign bus2.RD1D = bus.RD1D;           assign bus2.RD2D = bus.RD2D;
  assign bus2.SignImmD = bus.SignImmD;   assign bus2.RsD = bus.RsD;
  assign bus2.RtD = bus.RtD;             assign bus2.RdD = bus.RdD;
  assign bus2.RegWriteD = bus.RegWriteD; assign bus2.MemtoRegD = bus.MemtoRegD;
  assign bus2.MemWriteD = bus.MemWriteD; assign bus2.ALUSrcD = bus.ALUSrcD;
  assign bus2.RegDstD = bus.RegDstD;     assign bus2.ALUControlD = bus.ALUControlD;
  assign bus2.StallE = bus.StallE;       assign bus2.FlushE = bus.FlushE;
  assign bus2.ForwardAE = bus.ForwardAE; assign bus2.ForwardBE = bus.ForwardBE;
  assign bus2.ALUOutM = bus.ALUOutM;     assign bus2.ResultW = bus.ResultW;

  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .BubbleCnt(bubbleCnt), .StallCnt(stallCnt)
  );
  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .BubbleCnt(bubbleCnt2), .StallCnt(stallCnt2)
  );
`else
  id_ex_operand_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
`endif

  function automatic vec_in_t mkIn(
    logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
    logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
    logic rw, logic m2r, logic mw, logic aluSrc, logic regDst, logic [2:0] aluc,
    logic stall, logic flush, logic [1:0] fa, logic [1:0] fb,
    logic [31:0] aluOutM, logic [31:0] resultW);
    vec_in_t v;
    v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.rs = rs; v.rt = rt; v.rd = rd;
    v.regWrite = rw; v.memtoReg = m2r; v.memWrite = mw; v.aluSrc = aluSrc;
    v.regDst = regDst; v.aluCtrl = aluc; v.stall = stall; v.flush = flush;
    v.fwdA = fa; v.fwdB = fb; v.aluOutM = aluOutM; v.resultW = resultW;
    return v;
  endfunction

  function automatic vec_out_t mkOut(
    logic [31:0] srcA, logic [31:0] srcB, logic [31:0] wd, logic [2:0] aluc,
    logic [4:0] wr, logic [4:0] rs, logic [4:0] rt,
    logic rw, logic m2r, logic mw, logic valid);
    vec_out_t o;
    o.srcA = srcA; o.srcB = srcB; o.writeData = wd; o.aluCtrl = aluc;
    o.writeReg = wr; o.rs = rs; o.rt = rt; o.regWrite = rw; o.memtoReg = m2r;
    o.memWrite = mw; o.valid = valid;
    return o;
  endfunction

  task automatic drive(input vec_in_t v);
    bus.RD1D = v.rd1; bus.RD2D = v.rd2; bus.SignImmD = v.imm;
    bus.RsD = v.rs; bus.RtD = v.rt; bus.RdD = v.rd;
    bus.RegWriteD = v.regWrite; bus.MemtoRegD = v.memtoReg; bus.MemWriteD = v.memWrite;
    bus.ALUSrcD = v.aluSrc; bus.RegDstD = v.regDst; bus.ALUControlD = v.aluCtrl;
    bus.StallE = v.stall; bus.FlushE = v.flush;
    bus.ForwardAE = v.fwdA; bus.ForwardBE = v.fwdB;
    bus.ALUOutM = v.aluOutM; bus.ResultW = v.resultW;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  // push expectation, clock the stage, then pop and compare every E output
  task automatic applyAndCheck(input string n, input vec_in_t v, input vec_out_t e);
    vec_out_t ex;
    string    nm;
    drive(v);
    expQ.push_back(e);
    nameQ.push_back(n);
    step();
    ex = expQ.pop_front();
    nm = nameQ.pop_front();
    chk({nm, ".SrcAE"}, bus.SrcAE, ex.srcA);
    chk({nm, ".SrcBE"}, bus.SrcBE, ex.srcB);
    chk({nm, ".WriteDataE"}, bus.WriteDataE, ex.writeData);
    chk({nm, ".ALUControlE"}, 32'(bus.ALUControlE), 32'(ex.aluCtrl));
    chk({nm, ".WriteRegE"}, 32'(bus.WriteRegE), 32'(ex.writeReg));
    chk({nm, ".RsE"}, 32'(bus.RsE), 32'(ex.rs));
    chk({nm, ".RtE"}, 32'(bus.RtE), 32'(ex.rt));
    chk({nm, ".ctrl"}, {28'd0, bus.RegWriteE, bus.MemtoRegE, bus.MemWriteE, bus.ValidE},
        {28'd0, ex.regWrite, ex.memtoReg, ex.memWrite, ex.valid});
  endtask

  vec_in_t  busyIn;
  vec_in_t  idleIn;
  vec_out_t zeroOut;
  vec_out_t threeOut;

  initial begin
    zeroOut = mkOut(0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
    busyIn  = mkIn(32'h11, 32'h22, 32'hFFFF_FFFC, 4, 5, 9, 1, 1, 1, 1, 1, 3'b111,
                   0, 0, 2'b00, 2'b00, 32'h100, 32'h200);
    idleIn  = mkIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0);

    vecs[0] = '{"add_basic",
      mkIn(5, 7, 32'h10, 1, 2, 3, 1, 0, 0, 0, 0, ALU_ADD, 0, 0, 2'b00, 2'b00, 32'h100, 32'h200),
      mkOut(5, 7, 7, ALU_ADD, 2, 1, 2, 1, 0, 0, 1)};
    vecs[1] = '{"imm_rd",
      mkIn(32'h11, 32'h22, 32'hFFFF_FFFC, 4, 5, 9, 1, 1, 0, 1, 1, ALU_OR, 0, 0, 2'b00, 2'b00, 32'h100, 32'h200),
      mkOut(32'h11, 32'hFFFF_FFFC, 32'h22, ALU_OR, 9, 4, 5, 1, 1, 0, 1)};
    vecs[2] = '{"fwd_mem",
      mkIn(1, 32'h33, 0, 6, 7, 8, 0, 0, 1, 0, 0, ALU_SUB, 0, 0, 2'b10, 2'b10, 32'h100, 32'h200),
      mkOut(32'h100, 32'h100, 32'h100, ALU_SUB, 7, 6, 7, 0, 0, 1, 1)};
    vecs[3] = '{"fwd_wb",
      mkIn(1, 32'h33, 0, 6, 7, 8, 0, 0, 1, 0, 0, ALU_SUB, 0, 0, 2'b01, 2'b01, 32'h100, 32'h200),
      mkOut(32'h200, 32'h200, 32'h200, ALU_SUB, 7, 6, 7, 0, 0, 1, 1)};
    vecs[4] = '{"fwd_11",
      mkIn(1, 32'h33, 0, 6, 7, 8, 0, 0, 1, 0, 0, ALU_SUB, 0, 0, 2'b11, 2'b11, 32'h100, 32'h200),
      mkOut(1, 32'h33, 32'h33, ALU_SUB, 7, 6, 7, 0, 0, 1, 1)};
    vecs[5] = '{"stall_hold",
      mkIn(32'hAA, 32'hBB, 32'hCC, 9, 10, 11, 1, 1, 0, 1, 1, ALU_SLT, 1, 0, 2'b00, 2'b00, 32'h100, 32'h200),
      mkOut(1, 32'h33, 32'h33, ALU_SUB, 7, 6, 7, 0, 0, 1, 1)};
    vecs[6] = '{"flush_stall",
      mkIn(32'hAA, 32'hBB, 32'hCC, 9, 10, 11, 1, 1, 1, 1, 1, ALU_SLT, 1, 1, 2'b00, 2'b00, 32'h100, 32'h200),
      zeroOut};
    vecs[7] = '{"bubble_fwd",
      mkIn(32'hAA, 32'hBB, 32'hCC, 9, 10, 11, 1, 1, 1, 0, 0, ALU_MUL, 0, 1, 2'b10, 2'b01, 32'h100, 32'h200),
      mkOut(32'h100, 32'h200, 32'h200, ALU_AND, 0, 0, 0, 0, 0, 0, 0)};
    vecs[8] = '{"wide_pass",
      mkIn(32'hFFFF_FFFF, 32'h8000_0000, 32'h1234_5678, 31, 30, 29, 1, 1, 1, 0, 1, ALU_SLT, 0, 0, 2'b00, 2'b00, 32'h100, 32'h200),
      mkOut(32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, ALU_SLT, 29, 31, 30, 1, 1, 1, 1)};

    // reset edge with busy inputs clears everything
    rst_n = 1'b0;
    applyAndCheck("reset", busyIn, zeroOut);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyAndCheck(vecs[i].name, vecs[i].in, vecs[i].exp);
    end

    // load 3, hold through two stalls with changing inputs, resume, then flush over stall
    threeOut = mkOut(3, 3, 3, ALU_ADD, 4, 1, 3, 1, 0, 0, 1);
    applyAndCheck("load3", mkIn(3, 3, 0, 1, 3, 4, 1, 0, 0, 0, 1, ALU_ADD, 0, 0, 2'b00, 2'b00, 0, 0), threeOut);
    applyAndCheck("stall1", mkIn(8, 9, 1, 2, 2, 2, 0, 1, 1, 1, 0, ALU_OR, 1, 0, 2'b00, 2'b00, 0, 0), threeOut);
    applyAndCheck("stall2", mkIn(10, 11, 2, 5, 6, 7, 0, 0, 1, 0, 0, ALU_MUL, 1, 0, 2'b00, 2'b00, 0, 0), threeOut);
    applyAndCheck("resume", mkIn(10, 11, 2, 5, 6, 7, 0, 0, 1, 0, 0, ALU_MUL, 0, 0, 2'b00, 2'b00, 0, 0),
                  mkOut(10, 11, 11, ALU_MUL, 6, 5, 6, 0, 0, 1, 1));
    applyAndCheck("flush_wins", mkIn(3, 3, 0, 1, 3, 4, 1, 0, 1, 0, 1, ALU_ADD, 1, 1, 2'b00, 2'b00, 0, 0), zeroOut);

    // reset during a stall still clears
    applyAndCheck("reload", mkIn(3, 3, 0, 1, 3, 4, 1, 0, 0, 0, 1, ALU_ADD, 0, 0, 2'b00, 2'b00, 0, 0), threeOut);
    rst_n = 1'b0;
    applyAndCheck("reset_in_stall", mkIn(3, 3, 0, 1, 3, 4, 1, 0, 0, 0, 1, ALU_ADD, 1, 0, 2'b00, 2'b00, 0, 0), zeroOut);
    rst_n = 1'b1;

`ifdef IDEX_PERF_CNT_EN
    rst_n = 1'b0;
    drive(idleIn);
    step();
    rst_n = 1'b1;
    chk("cnt_reset", {bubbleCnt, stallCnt}, 32'h0);
    bus.FlushE = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.FlushE = 1'b0;
    bus.StallE = 1'b1;
    for (int i = 0; i < 2; i++) step();
    bus.StallE = 1'b0;
    step();
    chk("BubbleCnt", 32'(bubbleCnt), 32'd3);
    chk("StallCnt", 32'(stallCnt), 32'd2);
    chk("BubbleCnt_sat", 32'(bubbleCnt2), 32'd3);
    chk("StallCnt_w2", 32'(stallCnt2), 32'd2);
    bus.StallE = 1'b1;
    for (int i = 0; i < 3; i++) step();
    bus.StallE = 1'b0;
    step();
    chk("StallCnt5", 32'(stallCnt), 32'd5);
    chk("StallCnt_sat", 32'(stallCnt2), 32'd3);
`else
    drive(idleIn);
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
